// File: rtl/sa_ctrl_pkg.sv
// Shared types and defaults for the SA_sum_E array sequencer: FSM state
// encoding, PE mode codes and counter sizing helper.
package sa_ctrl_pkg;

  localparam int ROW_NUM_DEF  = 16;
  localparam int COL_NUM_DEF  = 16;
  localparam int K_WIDTH_DEF  = 16;
  localparam int MULT_LAT_DEF = 3;

  localparam logic [3:0] MODE_88 = 4'd0;
  localparam logic [3:0] MODE_18 = 4'd1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    FLUSH = 3'd3,
    MWAIT = 3'd4,
    DRAIN = 3'd5,
    DONE  = 3'd6
  } state_t;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sa_sum_e_ctrl_if.sv
// Operand and output-row handshake bundle between the sequencer (master)
// and the operand buffers / downstream row sink (slave).
interface sa_sum_e_ctrl_if;

  logic op_valid;
  logic op_ready;
  logic out_ready;
  logic out_valid;
  logic channel_out_en;
  logic row0_valid;

  modport master (
    input  op_valid,
    input  out_ready,
    output op_ready,
    output out_valid,
    output channel_out_en,
    output row0_valid
  );

  modport slave (
    output op_valid,
    output out_ready,
    input  op_ready,
    input  out_valid,
    input  channel_out_en,
    input  row0_valid
  );

endinterface

// File: rtl/sa_ctrl_cnt.sv
// Loadable down-counter with zero / one flags. Saturates at zero so it can
// never wrap; load has priority over decrement.
module sa_ctrl_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             is_zero,
  output logic             is_one
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign is_zero = (count_reg == '0);
  assign is_one  = (count_reg == WIDTH'(1));

endmodule

// File: rtl/sa_sum_e_ctrl.sv
// Job sequencer for the 16x16 SA_sum_E systolic array: clear, feed K operand
// beats, flush the skew, then drain ROW_NUM rows (or run a row-0 mult job).
module sa_sum_e_ctrl
  import sa_ctrl_pkg::*;
#(
  parameter int ROW_NUM      = ROW_NUM_DEF,
  parameter int COL_NUM      = COL_NUM_DEF,
  parameter int K_WIDTH      = K_WIDTH_DEF,
  parameter int FLUSH_CYCLES = ROW_NUM + COL_NUM - 2,
  parameter int MULT_LAT     = MULT_LAT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         cfg_mode,
  input  logic               cfg_mult,
  input  logic [K_WIDTH-1:0] cfg_k_len,
  input  logic [5:0]         cfg_row_idx,
  sa_sum_e_ctrl_if.master    bus,
  output logic               sa_en,
  output logic               sa_clear,
  output logic [3:0]         mode,
  output logic               mult_array_mode,
  output logic [5:0]         out_sa_row_idx,
  output logic               channel_out_reset,
  output logic               busy,
  output logic               done
);

  localparam int FW = cnt_width(FLUSH_CYCLES);
  localparam int DW = cnt_width(ROW_NUM);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES);
  localparam logic [FW-1:0] MWAIT_LOAD = FW'(MULT_LAT);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(ROW_NUM);

  state_t     state_reg;
  logic       sa_en_reg;
  logic       sa_clear_reg;
  logic       channel_out_reset_reg;
  logic       busy_reg;
  logic       done_reg;
  logic       row0_valid_reg;
  logic [3:0] mode_reg;
  logic       mult_reg;
  logic [5:0] row_idx_reg;

  logic beat_zero, beat_one;
  logic flush_zero, flush_one;
  logic drain_zero, drain_one;
  logic last_beat;
  logic drain_strobe;

  assign last_beat    = (state_reg == FEED) && bus.op_valid && beat_one;
  // The zero guard keeps the drain strictly at ROW_NUM strobes.
  assign drain_strobe = (state_reg == DRAIN) && bus.out_ready && !drain_zero;

  assign bus.op_ready       = (state_reg == FEED) && bus.op_valid;
  assign bus.out_valid      = drain_strobe;
  assign bus.channel_out_en = drain_strobe;
  assign bus.row0_valid     = row0_valid_reg;

  // FEED enables follow op_valid in the same cycle so the whole array stalls
  // with the operand stream; FLUSH/MWAIT enables come from the register.
  assign sa_en             = sa_en_reg || bus.op_ready;
  assign sa_clear          = sa_clear_reg;
  assign channel_out_reset = channel_out_reset_reg;
  assign busy              = busy_reg;
  assign done              = done_reg;
  assign mode              = mode_reg;
  assign mult_array_mode   = mult_reg;
  assign out_sa_row_idx    = row_idx_reg;

  sa_ctrl_cnt #(.WIDTH(K_WIDTH)) u_beat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     ((state_reg == IDLE) && start),
    .load_val (cfg_k_len),
    .dec      (bus.op_ready),
    .is_zero  (beat_zero),
    .is_one   (beat_one)
  );

  // Shared between the skew flush and the multiplier latency wait.
  sa_ctrl_cnt #(.WIDTH(FW)) u_flush_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (last_beat),
    .load_val (mult_reg ? MWAIT_LOAD : FLUSH_LOAD),
    .dec      ((state_reg == FLUSH) || (state_reg == MWAIT)),
    .is_zero  (flush_zero),
    .is_one   (flush_one)
  );

  sa_ctrl_cnt #(.WIDTH(DW)) u_drain_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (state_reg == CLEAR),
    .load_val (DRAIN_LOAD),
    .dec      (drain_strobe),
    .is_zero  (drain_zero),
    .is_one   (drain_one)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg             <= IDLE;
      sa_en_reg             <= 1'b0;
      sa_clear_reg          <= 1'b0;
      channel_out_reset_reg <= 1'b0;
      busy_reg              <= 1'b0;
      done_reg              <= 1'b0;
      row0_valid_reg        <= 1'b0;
      mode_reg              <= 4'd0;
      mult_reg              <= 1'b0;
      row_idx_reg           <= 6'd0;
    end else begin
      sa_clear_reg          <= 1'b0;
      channel_out_reset_reg <= 1'b0;
      done_reg              <= 1'b0;
      row0_valid_reg        <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg             <= CLEAR;
            mode_reg              <= cfg_mode;
            mult_reg              <= cfg_mult;
            row_idx_reg           <= cfg_row_idx;
            busy_reg              <= 1'b1;
            sa_clear_reg          <= 1'b1;
            channel_out_reset_reg <= 1'b1;
          end
        end
        CLEAR: begin
          if (!beat_zero) begin
            state_reg <= FEED;
          end else if (mult_reg) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end else begin
            state_reg <= DRAIN;
          end
        end
        FEED: begin
          if (last_beat) begin
            state_reg <= mult_reg ? MWAIT : FLUSH;
            sa_en_reg <= 1'b1;
          end
        end
        FLUSH: begin
          if (flush_one) begin
            state_reg <= DRAIN;
            sa_en_reg <= 1'b0;
          end
        end
        MWAIT: begin
          // Enabled for MULT_LAT cycles, then one result cycle with en low.
          if (flush_one) begin
            sa_en_reg      <= 1'b0;
            row0_valid_reg <= 1'b1;
          end else if (flush_zero) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_strobe && drain_one) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          sa_en_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sa_sum_e_ctrl.sv
// Job-level bench for sa_sum_e_ctrl: a table of job vectors with expected
// timing/counts, pushed to a scoreboard at start and checked when done fires.
module tb_sa_sum_e_ctrl;
  import sa_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  cfg_mode;
  logic        cfg_mult;
  logic [15:0] cfg_k_len;
  logic [5:0]  cfg_row_idx;
  logic        sa_en, sa_clear, mult_array_mode, channel_out_reset, busy, done;
  logic [3:0]  mode;
  logic [5:0]  out_sa_row_idx;

  sa_sum_e_ctrl_if bus();

  sa_sum_e_ctrl #(
    .ROW_NUM(16), .COL_NUM(16), .K_WIDTH(16), .FLUSH_CYCLES(30), .MULT_LAT(3)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .cfg_mode          (cfg_mode),
    .cfg_mult          (cfg_mult),
    .cfg_k_len         (cfg_k_len),
    .cfg_row_idx       (cfg_row_idx),
    .bus               (bus),
    .sa_en             (sa_en),
    .sa_clear          (sa_clear),
    .mode              (mode),
    .mult_array_mode   (mult_array_mode),
    .out_sa_row_idx    (out_sa_row_idx),
    .channel_out_reset (channel_out_reset),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mult;
    logic [3:0] mode;
    int         k;
    logic [5:0] row;
    int         stall_at;
    int         stall_len;
    int         or_pat;
    int         xstart;
    int         e_done;
    int         e_sa_en;
    int         e_beats;
    int         e_strobes;
    int         e_row0;
  } vec_t;

  typedef struct {
    int         done_t;
    int         sa_en_n;
    int         beats;
    int         strobes;
    int         row0_t;
    logic [3:0] mode;
    logic       mult;
    logic [5:0] row;
  } exp_t;

  vec_t vecs[7];
  vec_t abort_vec;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_sa_en"}, 32'(sa_en), 0);
    chk({tag, "_sa_clear"}, 32'(sa_clear), 0);
    chk({tag, "_mode"}, 32'(mode), 0);
    chk({tag, "_mult"}, 32'(mult_array_mode), 0);
    chk({tag, "_row_idx"}, 32'(out_sa_row_idx), 0);
    chk({tag, "_ch_reset"}, 32'(channel_out_reset), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_op_ready"}, 32'(bus.op_ready), 0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_ch_en"}, 32'(bus.channel_out_en), 0);
    chk({tag, "_row0_valid"}, 32'(bus.row0_valid), 0);
  endtask

  // One job: t=0 is the start cycle. Inputs change 1 time unit after posedge,
  // outputs are sampled on the falling edge.
  task automatic run_job(input int id, input vec_t v, input int abort_at);
    exp_t       e;
    bit         have_e = 0;
    int         t = 0;
    int         sa_en_n = 0, beats = 0, strb = 0, ov_n = 0, row0_n = 0;
    int         row0_t = -1, clr_n = 0, clr_t = -1, cor_n = 0, cor_t = -1;
    int         done_t = -1, done_n = 0, abort_t = -1;
    logic [3:0] m_d = '0;
    logic       mu_d = 1'b0;
    logic [5:0] r_d = '0;
    logic       b0 = 1'b1, b1 = 1'b0, b_after = 1'b1;

    sb.push_back('{v.e_done, v.e_sa_en, v.e_beats, v.e_strobes, v.e_row0, v.mode, v.mult, v.row});
    @(posedge clk); #1;
    forever begin
      reset = !(abort_at >= 0 && abort_t < 0 && strb == abort_at);
      if (!reset) abort_t = t;
      start = (t == 0) || (t == v.xstart);
      if (t == 0) begin
        cfg_mode = v.mode; cfg_mult = v.mult; cfg_k_len = 16'(v.k); cfg_row_idx = v.row;
      end else begin
        cfg_mode = 4'($urandom); cfg_mult = 1'($urandom);
        cfg_k_len = 16'($urandom); cfg_row_idx = 6'($urandom);
      end
      bus.op_valid  = !((t - 2) >= v.stall_at && (t - 2) < v.stall_at + v.stall_len);
      bus.out_ready = (v.or_pat == 0) ? 1'b1 : ((t % 3) == 1);
      @(negedge clk);
      if (abort_t >= 0 && t == abort_t + 1) begin
        check_idle("after_reset");
        chk("abort_strobes", strb, abort_at + 1);
        e = sb.pop_front();
        $display("job %0d: reset at cycle %0d after %0d strobes, job discarded", id, abort_t, strb);
        return;
      end
      if (sa_en) sa_en_n++;
      if (bus.op_ready) beats++;
      if (bus.channel_out_en) strb++;
      if (bus.out_valid) ov_n++;
      if (bus.row0_valid) begin row0_n++; if (row0_t < 0) row0_t = t; end
      if (sa_clear) begin clr_n++; if (clr_t < 0) clr_t = t; end
      if (channel_out_reset) begin cor_n++; if (cor_t < 0) cor_t = t; end
      if (t == 0) b0 = busy;
      if (t == 1) b1 = busy;
      if (done) begin
        done_n++;
        if (done_t < 0) begin
          done_t = t; m_d = mode; mu_d = mult_array_mode; r_d = out_sa_row_idx;
          e = sb.pop_front(); have_e = 1;
        end
      end
      if (done_t >= 0 && t == done_t + 1) b_after = busy;
      if (done_t >= 0 && t == done_t + 3) break;
      if (t >= 400) break;
      @(posedge clk); #1; t++;
    end
    if (!have_e) begin
      chk("done_timeout", done_t, v.e_done);
      e = sb.pop_front();
    end
    chk("done_cycle", done_t, e.done_t);
    chk("done_count", done_n, 1);
    chk("sa_en_cycles", sa_en_n, e.sa_en_n);
    chk("op_ready_beats", beats, e.beats);
    chk("ch_en_strobes", strb, e.strobes);
    chk("out_valid_rows", ov_n, e.strobes);
    chk("row0_cycle", row0_t, e.row0_t);
    chk("row0_count", row0_n, (e.row0_t >= 0) ? 1 : 0);
    chk("sa_clear_count", clr_n, 1);
    chk("sa_clear_cycle", clr_t, 1);
    chk("ch_reset_count", cor_n, 1);
    chk("ch_reset_cycle", cor_t, 1);
    chk("busy_at_start", 32'(b0), 0);
    chk("busy_after_start", 32'(b1), 1);
    chk("busy_after_done", 32'(b_after), 0);
    chk("latched_mode", 32'(m_d), 32'(e.mode));
    chk("latched_mult", 32'(mu_d), 32'(e.mult));
    chk("latched_row_idx", 32'(r_d), 32'(e.row));
    $display("job %0d: mult=%0d k=%0d done@%0d sa_en=%0d beats=%0d strobes=%0d row0@%0d",
             id, v.mult, v.k, done_t, sa_en_n, beats, strb, row0_t);
  endtask

  initial begin
    //          mult  mode     k  row     st sl or xs   done sa_en beats strb row0
    vecs[0] = '{1'b0, MODE_88, 4, 6'd3,   0, 0, 0, -1,  52,  34,   4,    16,  -1};
    vecs[1] = '{1'b0, MODE_88, 4, 6'd5,   1, 3, 0, -1,  55,  34,   4,    16,  -1};
    vecs[2] = '{1'b0, MODE_18, 2, 6'd63,  0, 0, 1, -1,  80,  32,   2,    16,  -1};
    vecs[3] = '{1'b1, MODE_18, 1, 6'd0,   0, 0, 0, -1,  7,   4,    1,    0,   6};
    vecs[4] = '{1'b0, MODE_88, 0, 6'd9,   0, 0, 0, 5,   18,  0,    0,    16,  -1};
    vecs[5] = '{1'b1, MODE_88, 0, 6'd12,  0, 0, 0, -1,  2,   0,    0,    0,   -1};
    vecs[6] = '{1'b1, MODE_18, 3, 6'd33,  0, 2, 0, -1,  11,  6,    3,    0,   10};
    abort_vec = '{1'b0, MODE_18, 4, 6'd42, 0, 0, 0, -1, 52, 34, 4, 16, -1};

    reset = 1'b0; start = 1'b0;
    cfg_mode = '0; cfg_mult = 1'b0; cfg_k_len = '0; cfg_row_idx = '0;
    bus.op_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.op_valid = 1'b1; bus.out_ready = 1'b1; start = 1'b1;
    cfg_mode = MODE_18; cfg_mult = 1'b1; cfg_k_len = 16'd4; cfg_row_idx = 6'd7;
    @(negedge clk);
    check_idle("in_reset");
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("start_during_reset_ignored", 32'(busy), 0);

    for (int i = 0; i < 7; i++) run_job(i, vecs[i], -1);
    run_job(7, abort_vec, 7);
    run_job(8, vecs[0], -1);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
